// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer's keypad front end.
// Holds the special key codes and the (row, column) -> key code map,
// plus the key code -> one-hot digit decode used for the keypad bus.
package timer_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Map a matrix position to its key code: r0={1,2,3} r1={4,5,6} r2={7,8,9} r3={*,0,#}
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Digits 0..9 become a one-hot bit; '*' and '#' have no digit bit
  function automatic logic [9:0] code_to_onehot(input logic [3:0] code);
    logic [9:0] oh;
    oh = '0;
    if (code <= 4'd9) begin
      oh = 10'd1 << code;
    end
    return oh;
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchroniser for asynchronous, active-low input lines.
// Resets to all-ones so idle (released) lines read as inactive.
// Latency is two clk cycles from input change to output change.
module kp_sync2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two-stage capture of the asynchronous lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks an active-low row, debounces press and release,
// and holds the accepted key as one-hot digit / star / hash plus a code.
// key_strobe pulses once in the first cycle a key output rises.
module keypad_scanner
  import timer_pkg::*;
#(
  parameter int SETTLE   = 3,
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic [3:0] key_code,
  output logic       key_strobe
);

  localparam int CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  state_t        r_state,      w_state_nxt;
  logic [1:0]    r_row,        w_row_nxt;
  logic [CW-1:0] r_settle_cnt, w_settle_nxt;
  logic [CW-1:0] r_deb_cnt,    w_deb_nxt;
  logic [2:0]    r_cap_col,    w_cap_nxt;
  logic [9:0]    r_keypad,     w_keypad_nxt;
  logic          r_star,       w_star_nxt;
  logic          r_hash,       w_hash_nxt;
  logic [3:0]    r_code,       w_code_nxt;
  logic          r_strobe,     w_strobe_nxt;

  logic [2:0]    w_col;
  logic          w_col_single;
  logic [1:0]    w_cap_idx;
  logic [3:0]    w_cap_code;

  kp_sync2 #(.W(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (key_col),
    .o_q (w_col)
  );

  // Exactly one column pulled low is the only pattern accepted as a key
  assign w_col_single = (w_col == 3'b110) || (w_col == 3'b101) || (w_col == 3'b011);

  // Column index of the captured pattern and the key it names on the held row
  always_comb begin
    w_cap_idx = 2'd0;
    case (r_cap_col)
      3'b101:  w_cap_idx = 2'd1;
      3'b011:  w_cap_idx = 2'd2;
      default: w_cap_idx = 2'd0;
    endcase
    w_cap_code = keymap(r_row, w_cap_idx);
  end

  // State, scan position, counters and registered key outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SCAN;
      r_row        <= 2'd0;
      r_settle_cnt <= '0;
      r_deb_cnt    <= '0;
      r_cap_col    <= 3'b111;
      r_keypad     <= '0;
      r_star       <= 1'b0;
      r_hash       <= 1'b0;
      r_code       <= 4'd0;
      r_strobe     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_deb_cnt    <= w_deb_nxt;
      r_cap_col    <= w_cap_nxt;
      r_keypad     <= w_keypad_nxt;
      r_star       <= w_star_nxt;
      r_hash       <= w_hash_nxt;
      r_code       <= w_code_nxt;
      r_strobe     <= w_strobe_nxt;
    end
  end

  // Scan / debounce sequencing; outputs only move on entry to and exit from PRESSED
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_settle_nxt = r_settle_cnt;
    w_deb_nxt    = r_deb_cnt;
    w_cap_nxt    = r_cap_col;
    w_keypad_nxt = r_keypad;
    w_star_nxt   = r_star;
    w_hash_nxt   = r_hash;
    w_code_nxt   = r_code;
    w_strobe_nxt = 1'b0;

    case (r_state)
      SCAN: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_settle_nxt = '0;
          if (w_col_single) begin
            w_cap_nxt   = w_col;
            w_deb_nxt   = '0;
            w_state_nxt = PRESS_DB;
          end else begin
            // idle or multi-key pattern: move on to the next row
            w_row_nxt = r_row + 2'd1;
          end
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end

      PRESS_DB: begin
        if (w_col == r_cap_col) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_deb_nxt    = '0;
            w_state_nxt  = PRESSED;
            w_code_nxt   = w_cap_code;
            w_keypad_nxt = code_to_onehot(w_cap_code);
            w_star_nxt   = (w_cap_code == KEY_STAR);
            w_hash_nxt   = (w_cap_code == KEY_HASH);
            w_strobe_nxt = 1'b1;
          end else begin
            w_deb_nxt = r_deb_cnt + 1'b1;
          end
        end else begin
          // bounce: give up on this row without touching the outputs
          w_row_nxt    = r_row + 2'd1;
          w_settle_nxt = '0;
          w_state_nxt  = SCAN;
        end
      end

      PRESSED: begin
        if (w_col == 3'b111) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_deb_nxt    = '0;
            w_row_nxt    = r_row + 2'd1;
            w_settle_nxt = '0;
            w_state_nxt  = SCAN;
            w_keypad_nxt = '0;
            w_star_nxt   = 1'b0;
            w_hash_nxt   = 1'b0;
            w_code_nxt   = 4'd0;
          end else begin
            w_deb_nxt = r_deb_cnt + 1'b1;
          end
        end else begin
          // any non-idle sample restarts the release count
          w_deb_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = SCAN;
      end
    endcase
  end

  assign key_row    = ~(4'b0001 << r_row);
  assign keypad     = r_keypad;
  assign key_star   = r_star;
  assign key_hash   = r_hash;
  assign key_code   = r_code;
  assign key_strobe = r_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a matrix model and a strobe scoreboard.
// Stimulus pushes the key code a press must report; a monitor pops on each strobe.
// Directed scenarios first, then randomized presses, bounces and release glitches.
module tb_keypad_scanner;

  localparam int SETTLE   = 3;
  localparam int DEBOUNCE = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic [9:0] keypad;
  logic       key_star;
  logic       key_hash;
  logic [3:0] key_code;
  logic       key_strobe;

  logic [11:0] down;  // pressed keys, index = row*3 + col
  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_col    (key_col),
    .key_row    (key_row),
    .keypad     (keypad),
    .key_star   (key_star),
    .key_hash   (key_hash),
    .key_code   (key_code),
    .key_strobe (key_strobe)
  );

  // Matrix: a pressed key pulls its column low only while its row is driven low
  always_comb begin
    key_col = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (down[r*3 + c] && !key_row[r]) key_col[c] = 1'b0;
  end

  function automatic int pos_code(int pos);
    if (pos == 9)  return 10;
    if (pos == 10) return 0;
    if (pos == 11) return 11;
    return pos + 1;
  endfunction

  function automatic logic [9:0] onehot(int code);
    logic [9:0] v;
    v = '0;
    if (code >= 0 && code <= 9) v[code] = 1'b1;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: row drive sanity every cycle, scoreboard pop on every strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("row_one_low", $countones(~key_row), 1);
        if (key_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", int'(key_code), -1);
          end else begin
            int e;
            e = exp_q.pop_front();
            check("strobe_code", int'(key_code), e);
            check("strobe_keypad", int'(keypad), int'(onehot(e)));
            check("strobe_star", int'(key_star), int'(e == 10));
            check("strobe_hash", int'(key_hash), int'(e == 11));
          end
        end
      end
    end
  end

  // Wait (bounded) for all key outputs to drop, then confirm every expected strobe was seen
  task automatic wait_idle(string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      cycles(1);
      if (keypad == 0 && !key_star && !key_hash && key_code == 0) ok = 1;
    end
    check(name, ok, 1);
    cycles(20);
    check("missing_strobe", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Press long enough to be accepted, optionally with a short release glitch while held
  task automatic long_press(int pos, int n, int g_at, int g_len);
    int e;
    e = pos_code(pos);
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      down[pos] = !(g_len > 0 && i >= g_at && i < g_at + g_len);
      cycles(1);
      if (g_len > 0 && i >= g_at && i < g_at + g_len + 4)
        check("glitch_hold", int'(keypad), int'(onehot(e)));
    end
    check("held_keypad", int'(keypad), int'(onehot(e)));
    check("held_code", int'(key_code), e);
    check("held_star", int'(key_star), int'(e == 10));
    check("held_hash", int'(key_hash), int'(e == 11));
    down[pos] = 1'b0;
    wait_idle("release_idle");
  endtask

  // Press too short to survive debounce: nothing may be reported
  task automatic short_press(int pos, int n);
    down[pos] = 1'b1;
    cycles(n);
    down[pos] = 1'b0;
    cycles(45);
    check("bounce_keypad", int'(keypad), 0);
    check("bounce_code", int'(key_code), 0);
  endtask

  initial begin
    logic [3:0] er;
    int n;
    int ok;
    rst  = 1'b1;
    down = '0;
    cycles(3);

    // Reset state
    check("rst_row", int'(key_row), 4'b1110);
    check("rst_keypad", int'(keypad), 0);
    check("rst_star", int'(key_star), 0);
    check("rst_hash", int'(key_hash), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_strobe", int'(key_strobe), 0);

    // Idle scan: one row step every SETTLE cycles, wrapping after r3
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) cycles(1);
      er = ~(4'b0001 << ((k / SETTLE) % 4));
      check("scan_row", int'(key_row), int'(er));
      check("scan_keypad", int'(keypad), 0);
    end

    // '5' held, then exact release latency
    exp_q.push_back(5);
    down[4] = 1'b1;
    cycles(100);
    check("five_keypad", int'(keypad), int'(onehot(5)));
    check("five_code", int'(key_code), 5);
    down[4] = 1'b0;
    n = 0;
    ok = 0;
    while (n < 60 && ok == 0) begin
      cycles(1);
      n++;
      if (keypad == 0) ok = 1;
    end
    check("release_latency", n, DEBOUNCE + 2);
    cycles(20);
    check("missing_strobe", exp_q.size(), 0);
    exp_q.delete();

    // '0' then '#'
    long_press(10, 90, 0, 0);
    long_press(11, 90, 0, 0);

    // Bounce on '7', then a release glitch while '7' is held
    short_press(6, 10);
    long_press(6, 100, 50, 5);

    // '1' and '2' together on one row: invalid, nothing reported
    down[0] = 1'b1;
    down[1] = 1'b1;
    cycles(100);
    check("multi_keypad", int'(keypad), 0);
    check("multi_code", int'(key_code), 0);
    down = '0;
    cycles(30);

    // '1' held, then '9' added on another row: only '1' reported
    exp_q.push_back(1);
    down[0] = 1'b1;
    cycles(60);
    down[8] = 1'b1;
    cycles(60);
    check("rollover_keypad", int'(keypad), int'(onehot(1)));
    check("rollover_code", int'(key_code), 1);
    down = '0;
    wait_idle("rollover_idle");

    // Async reset while '3' held, then re-detection as a fresh press
    exp_q.push_back(3);
    down[2] = 1'b1;
    cycles(60);
    check("pre_rst_code", int'(key_code), 3);
    rst = 1'b1;
    #1;
    check("async_rst_keypad", int'(keypad), 0);
    check("async_rst_code", int'(key_code), 0);
    check("async_rst_strobe", int'(key_strobe), 0);
    check("async_rst_row", int'(key_row), 4'b1110);
    check("missing_strobe_pre_rst", exp_q.size(), 0);
    cycles(3);
    rst = 1'b0;
    exp_q.push_back(3);
    cycles(60);
    check("post_rst_code", int'(key_code), 3);
    check("post_rst_keypad", int'(keypad), int'(onehot(3)));
    down = '0;
    wait_idle("post_rst_idle");

    // Randomized presses across the whole keypad and scan phases
    for (int it = 0; it < 24; it++) begin
      int pos;
      cycles($urandom_range(0, 11));
      pos = $urandom_range(0, 11);
      if ($urandom_range(0, 3) == 0) begin
        short_press(pos, $urandom_range(1, 15));
      end else if ($urandom_range(0, 1) == 0) begin
        long_press(pos, $urandom_range(60, 120), 50, $urandom_range(1, 5));
      end else begin
        long_press(pos, $urandom_range(60, 120), 0, 0);
      end
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
